// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding with CPOL/CPHA decode, default word
// width and toggle synchroniser depth.
package spi_pkg;

  // Mode index is {CPOL, CPHA}; the PHY itself only sees the normalised clock.
  typedef enum logic [1:0] {
    SPI_MODE_0 = 2'b00,
    SPI_MODE_1 = 2'b01,
    SPI_MODE_2 = 2'b10,
    SPI_MODE_3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e mode);
    return mode[0];
  endfunction

  localparam spi_mode_e SPI_MODE = SPI_MODE_0;
  localparam logic      SPI_CPOL = mode_cpol(SPI_MODE);
  localparam logic      SPI_CPHA = mode_cpha(SPI_MODE);

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int SYNC_STAGES        = 2;

endpackage

// File: rtl/spi_slave_phy_toggle_sync.sv
// toggle_sync: multi-flop synchroniser carrying a system-domain toggle into
// the spi_clk domain.
module toggle_sync
  import spi_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic arstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: flops use <= so every stage samples its neighbour's pre-edge value;
  // blocking assignments here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_phy.sv
// spi_slave_phy: SPI slave shift engine with toggle handshakes to the system
// domain. Define SPI_SLAVE_PHY_ERR_EN to build the sticky overrun/underrun flags.
module spi_slave_phy
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  arstn_i,
  input  logic                  spi_clk,
  input  logic                  spi_cs_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_toggle_i,
  output logic                  tx_ack_toggle_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_toggle_o,
  input  logic                  rx_ack_toggle_i,
  output logic                  overrun_o,
  output logic                  underrun_o
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  frame_rstn;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  first_word_q;
  logic [DATA_WIDTH-2:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_toggle_q, rx_toggle_d;
  logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
  logic                  tx_ack_toggle_q, tx_ack_toggle_d;
  logic                  tx_sync;
  logic                  tx_pending;
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  first_bit, last_bit;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_tx_sync (
    .clk     (spi_clk),
    .arstn_i (arstn_i),
    .d_i     (tx_toggle_i),
    .q_o     (tx_sync)
  );

  // Deselect restarts word framing immediately, without waiting for a clock.
  assign frame_rstn = arstn_i & ~spi_cs_i;

  always_ff @(posedge spi_clk or negedge frame_rstn) begin
    if (!frame_rstn) begin
      bit_cnt_q    <= '0;
      first_word_q <= 1'b1;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      first_word_q <= 1'b0;
    end
  end

  assign first_bit  = (bit_cnt_q == '0);
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign tx_pending = (tx_sync != tx_ack_toggle_q);
  assign sel_word   = tx_pending ? tx_data_i : '1;

  // NOTE: every signal gets its default before any branch, so no path holds a
  // previous value and no latch is inferred.
  always_comb begin
    bit_cnt_d       = last_bit ? '0 : bit_cnt_q + 1'b1;
    rx_shreg_d      = {rx_shreg_q[DATA_WIDTH-3:0], spi_mosi_i};
    rx_data_d       = rx_data_q;
    rx_toggle_d     = rx_toggle_q;
    tx_shreg_d      = {tx_shreg_q[DATA_WIDTH-2:0], 1'b1};
    tx_ack_toggle_d = tx_ack_toggle_q;

    if (last_bit) begin
      rx_data_d   = {rx_shreg_q, spi_mosi_i};
      rx_toggle_d = ~rx_toggle_q;
    end

    // The word's MSB already left combinationally, so load the remainder.
    if (first_bit) begin
      tx_shreg_d = {sel_word[DATA_WIDTH-2:0], 1'b1};
      if (tx_pending) begin
        tx_ack_toggle_d = ~tx_ack_toggle_q;
      end
    end
  end

  always_ff @(posedge spi_clk or negedge arstn_i) begin
    if (!arstn_i) begin
      rx_shreg_q      <= '0;
      rx_data_q       <= '0;
      rx_toggle_q     <= 1'b0;
      tx_shreg_q      <= '1;
      tx_ack_toggle_q <= 1'b0;
    end else if (!spi_cs_i) begin
      rx_shreg_q      <= rx_shreg_d;
      rx_data_q       <= rx_data_d;
      rx_toggle_q     <= rx_toggle_d;
      tx_shreg_q      <= tx_shreg_d;
      tx_ack_toggle_q <= tx_ack_toggle_d;
    end
  end

  assign spi_miso_o      = spi_cs_i  ? 1'bz
                         : first_bit ? sel_word[DATA_WIDTH-1]
                         :             tx_shreg_q[DATA_WIDTH-1];
  assign rx_data_o       = rx_data_q;
  assign rx_toggle_o     = rx_toggle_q;
  assign tx_ack_toggle_o = tx_ack_toggle_q;

`ifdef SPI_SLAVE_PHY_ERR_EN
  logic overrun_q, underrun_q;
  logic overrun_evt, underrun_evt;

  assign overrun_evt  = last_bit & (rx_toggle_q != rx_ack_toggle_i);
  assign underrun_evt = first_bit & ~tx_pending;

  // Flags survive until the first edge of the next frame, which clears them
  // before that edge's own events are folded in.
  always_ff @(posedge spi_clk or negedge arstn_i) begin
    if (!arstn_i) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!spi_cs_i) begin
      overrun_q  <= (overrun_q  & ~first_word_q) | overrun_evt;
      underrun_q <= (underrun_q & ~first_word_q) | underrun_evt;
    end
  end

  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = rx_ack_toggle_i ^ first_word_q;

  assign overrun_o  = 1'b0;
  assign underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_phy.sv
// Self-checking bench for spi_slave_phy (DATA_WIDTH = 8): directed frames plus
// random frames checked against a word-level model of the slave.
module tb_spi_slave_phy;

  localparam int W = 8;
`ifdef SPI_SLAVE_PHY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         arstn_i;
  logic         spi_clk;
  logic         spi_cs_i;
  logic         spi_mosi_i;
  wire          spi_miso_o;
  logic [W-1:0] tx_data_i;
  logic         tx_toggle_i;
  logic         tx_ack_toggle_o;
  logic [W-1:0] rx_data_o;
  logic         rx_toggle_o;
  logic         rx_ack_toggle_i;
  logic         overrun_o;
  logic         underrun_o;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;

  // Word-level model of the slave as seen from the pins.
  logic         m_ack;
  logic         m_rx_tog;
  logic [W-1:0] m_rx_data;
  logic         m_ovr;
  logic         m_udr;
  int           m_offer_edge;
  logic [63:0]  miso_cap;

  spi_slave_phy #(
    .DATA_WIDTH (W)
  ) dut (
    .arstn_i         (arstn_i),
    .spi_clk         (spi_clk),
    .spi_cs_i        (spi_cs_i),
    .spi_mosi_i      (spi_mosi_i),
    .spi_miso_o      (spi_miso_o),
    .tx_data_i       (tx_data_i),
    .tx_toggle_i     (tx_toggle_i),
    .tx_ack_toggle_o (tx_ack_toggle_o),
    .rx_data_o       (rx_data_o),
    .rx_toggle_o     (rx_toggle_o),
    .rx_ack_toggle_i (rx_ack_toggle_i),
    .overrun_o       (overrun_o),
    .underrun_o      (underrun_o)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  always @(posedge spi_clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data_o),       32'(m_rx_data));
    check({tag, "_rx_tog"},  32'(rx_toggle_o),     32'(m_rx_tog));
    check({tag, "_tx_ack"},  32'(tx_ack_toggle_o), 32'(m_ack));
    check({tag, "_ovr"},     32'(overrun_o),       32'(m_ovr));
    check({tag, "_udr"},     32'(underrun_o),      32'(m_udr));
  endtask

  task automatic model_reset();
    m_ack        = 1'b0;
    m_rx_tog     = 1'b0;
    m_rx_data    = '0;
    m_ovr        = 1'b0;
    m_udr        = 1'b0;
    m_offer_edge = -100;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge spi_clk);
  endtask

  task automatic offer(input logic [W-1:0] w);
    @(negedge spi_clk);
    tx_data_i    = w;
    tx_toggle_i  = ~tx_toggle_i;
    m_offer_edge = edge_cnt;
  endtask

  // One chip-select frame of n rising edges; MOSI bits come MSB-first from
  // stream[n-1:0]. A word offered at edge count E is visible from edge E+3 on.
  task automatic run_frame(input int n, input logic [63:0] stream, input string tag);
    logic [W-1:0] word_out;
    int           pos;
    word_out = '1;
    miso_cap = '0;
    for (int e = 0; e < n; e++) begin
      @(negedge spi_clk);
      spi_cs_i   = 1'b0;
      spi_mosi_i = stream[n-1-e];
      pos        = e % W;
      if (e == 0 && ERR_EN) begin
        m_ovr = 1'b0;
        m_udr = 1'b0;
      end
      if (pos == 0) begin
        if ((tx_toggle_i !== m_ack) && (edge_cnt + 1 >= m_offer_edge + 3)) begin
          word_out = tx_data_i;
          m_ack    = ~m_ack;
        end else begin
          word_out = '1;
          if (ERR_EN) m_udr = 1'b1;
        end
      end
      if (pos == W-1) begin
        if (ERR_EN && (m_rx_tog !== rx_ack_toggle_i)) m_ovr = 1'b1;
        m_rx_data = stream[n+W-2-e -: W];
        m_rx_tog  = ~m_rx_tog;
      end
      #1;
      miso_cap = {miso_cap[62:0], spi_miso_o};
      check($sformatf("%s_miso_e%0d", tag, e), 32'(spi_miso_o), 32'(word_out[W-1-pos]));
      @(posedge spi_clk);
      #1;
      check_outputs($sformatf("%s_e%0d", tag, e));
    end
    @(negedge spi_clk);
    spi_cs_i = 1'b1;
  endtask

  initial begin
    arstn_i         = 1'b0;
    spi_cs_i        = 1'b1;
    spi_mosi_i      = 1'b0;
    tx_data_i       = '0;
    tx_toggle_i     = 1'b0;
    rx_ack_toggle_i = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    idle(3);
    arstn_i = 1'b1;
    idle(3);

    // Offered word goes out MSB first while an 8-bit word comes in.
    offer(8'hA5);
    idle(3);
    run_frame(8, 64'h3C, "r33");
    check("r33_miso_word", 32'(miso_cap[7:0]), 32'hA5);
    check("r33_rx_data",   32'(rx_data_o),     32'h3C);
    check("r33_rx_tog",    32'(rx_toggle_o),   32'h1);
    check("r33_tx_ack",    32'(tx_ack_toggle_o), 32'h1);
    rx_ack_toggle_i = m_rx_tog;

    // No offer: idle pattern and underrun, cleared by the next frame.
    run_frame(8, 64'(W'($urandom)), "r34");
    check("r34_miso_word", 32'(miso_cap[7:0]), 32'hFF);
    check("r34_udr",       32'(underrun_o),    32'(ERR_EN));
    rx_ack_toggle_i = m_rx_tog;
    offer(8'h5A);
    idle(3);
    run_frame(8, 64'hC7, "r34b");
    check("r34b_miso_word", 32'(miso_cap[7:0]), 32'h5A);
    check("r34b_udr",       32'(underrun_o),    32'h0);
    rx_ack_toggle_i = m_rx_tog;

    // Two words in one frame, second never acknowledged.
    run_frame(16, 64'h1122, "r35");
    check("r35_rx_data", 32'(rx_data_o), 32'h22);
    check("r35_ovr",     32'(overrun_o), 32'(ERR_EN));
    rx_ack_toggle_i = m_rx_tog;

    // Aborted partial word is discarded.
    run_frame(5, 64'h15, "r36a");
    idle(1);
    run_frame(8, 64'h81, "r36");
    check("r36_rx_data", 32'(rx_data_o), 32'h81);
    rx_ack_toggle_i = m_rx_tog;

    // Offer arriving one edge before the load edge waits for the next word.
    offer(8'h3E);
    run_frame(8, 64'h42, "r25a");
    check("r25a_miso_word", 32'(miso_cap[7:0]), 32'hFF);
    rx_ack_toggle_i = m_rx_tog;
    idle(1);
    run_frame(8, 64'h24, "r25b");
    check("r25b_miso_word", 32'(miso_cap[7:0]), 32'h3E);
    rx_ack_toggle_i = m_rx_tog;

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) != 0 && tx_toggle_i === m_ack) begin
        offer(W'($urandom));
        idle(3);
      end
      if ($urandom_range(0, 1) != 0) rx_ack_toggle_i = m_rx_tog;
      run_frame(int'($urandom_range(1, 2*W)), {$urandom, $urandom}, $sformatf("rnd%0d", i));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset asserted just before the fourth edge of a frame.
    rx_ack_toggle_i = m_rx_tog;
    offer(8'h77);
    idle(3);
    @(negedge spi_clk);
    spi_cs_i = 1'b0;
    repeat (3) @(posedge spi_clk);
    @(negedge spi_clk);
    arstn_i         = 1'b0;
    tx_toggle_i     = 1'b0;
    rx_ack_toggle_i = 1'b0;
    model_reset();
    #1;
    check_outputs("r37_async");
    check("r37_miso_idle", 32'(spi_miso_o), 32'h1);
    @(posedge spi_clk);
    #1;
    check_outputs("r37_hold");
    @(negedge spi_clk);
    spi_cs_i = 1'b1;
    @(negedge spi_clk);
    arstn_i = 1'b1;
    idle(2);

    offer(8'hC3);
    idle(3);
    run_frame(8, 64'h96, "post_rst");
    check("post_rst_miso_word", 32'(miso_cap[7:0]), 32'hC3);
    check("post_rst_rx_data",   32'(rx_data_o),     32'h96);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
